processorci_wb_mem_responder: RTL and testbench

//  Wishbone-classic responder (target) for the core bus: answers core_cyc/core_stb requests

---
 rtl/processorci_wb_mem_responder.sv | 133 +++++++++++++
 tb/tb_processorci_wb_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processorci_wb_mem_responder.sv
// Wishbone-classic memory target: a 32-bit word RAM with byte lanes and a fixed
// number of wait states; in-range accesses complete with ack, all others with err.
module processorci_wb_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter string       MEMORY_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o
);
    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_count;
    logic          r_we;
    logic [3:0]    r_wstrb;
    logic [AW-1:0] r_index;
    logic [31:0]   r_data;
    logic          r_in_range;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [MEM_WORDS];

    logic [31:0]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_index;
    logic [AW-1:0] w_rd_index;
    logic          w_start;
    logic          w_mem_we;
    logic [3:0]    w_lane_we;

    // Addresses below the base wrap to a huge offset, so one unsigned compare covers both ends.
    assign w_offset   = addr_i - BASE_ADDR;
    assign w_in_range = (w_offset < MEM_BYTES);
    assign w_index    = w_offset[AW+1:2];
    assign w_start    = cyc_i & stb_i;

    // In IDLE the RAM is read with the live address so the word is ready even with zero wait states.
    assign w_rd_index = (r_state == ST_IDLE) ? w_index : r_index;
    assign w_mem_we   = (r_state == ST_RESP) & r_we & r_in_range;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane_we[gi] = w_mem_we & r_wstrb[gi];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_lane_we[b]) begin
                r_mem[r_index][8*b +: 8] <= r_data[8*b +: 8];
            end
        end
        r_rdata <= r_mem[w_rd_index];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_we       <= 1'b0;
            r_wstrb    <= 4'd0;
            r_index    <= '0;
            r_data     <= 32'd0;
            r_in_range <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_we       <= we_i;
                        r_wstrb    <= wstrb_i;
                        r_index    <= w_index;
                        r_data     <= data_i;
                        r_in_range <= w_in_range;
                        if (WAIT_STATES > 0) begin
                            r_state <= ST_WAIT;
                            r_count <= WAIT_INIT;
                        end else begin
                            r_state <= ST_RESP;
                            r_ack   <= w_in_range;
                            r_err   <= ~w_in_range;
                        end
                    end
                end
                ST_WAIT: begin
                    // Dropping cyc_i abandons the access before anything is committed.
                    if (!cyc_i) begin
                        r_state <= ST_IDLE;
                        r_count <= 4'd0;
                    end else if (r_count == 4'd0) begin
                        r_state <= ST_RESP;
                        r_ack   <= r_in_range;
                        r_err   <= ~r_in_range;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o  = r_ack;
    assign err_o  = r_err;
    assign data_o = (r_ack & ~r_we) ? r_rdata : 32'd0;

endmodule

// File: tb/tb_processorci_wb_mem_responder.sv
// Directed bench for processorci_wb_mem_responder: three instances with 0, 1 and 3 wait states.
module tb_processorci_wb_mem_responder;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NDUT];
    logic        cyc   [NDUT];
    logic        stb   [NDUT];
    logic        we    [NDUT];
    logic [3:0]  wstrb [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];

    int exp_lat [NDUT] = '{1, 2, 4};
    int n_checks = 0;
    int n_fail   = 0;

    processorci_wb_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0), .MEMORY_FILE("")
    ) u_dut_w0 (
        .clk(clk), .rst_n(rst_n[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .wstrb_i(wstrb[0]), .addr_i(addr[0]), .data_i(wdata[0]), .data_o(rdata[0]),
        .ack_o(ack[0]), .err_o(err[0])
    );

    processorci_wb_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1), .MEMORY_FILE("")
    ) u_dut_w1 (
        .clk(clk), .rst_n(rst_n[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .wstrb_i(wstrb[1]), .addr_i(addr[1]), .data_i(wdata[1]), .data_o(rdata[1]),
        .ack_o(ack[1]), .err_o(err[1])
    );

    processorci_wb_mem_responder #(
        .MEM_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3), .MEMORY_FILE("")
    ) u_dut_w3 (
        .clk(clk), .rst_n(rst_n[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
        .wstrb_i(wstrb[2]), .addr_i(addr[2]), .data_i(wdata[2]), .data_o(rdata[2]),
        .ack_o(ack[2]), .err_o(err[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive_req(input int k, input logic w, input logic [3:0] s,
                             input logic [31:0] a, input logic [31:0] d);
        cyc[k]   = 1'b1;
        stb[k]   = 1'b1;
        we[k]    = w;
        wstrb[k] = s;
        addr[k]  = a;
        wdata[k] = d;
    endtask

    task automatic drop_req(input int k);
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
        we[k]  = 1'b0;
    endtask

    // Counts edges until ack/err is seen at a falling edge; gives up after 40 cycles.
    task automatic wait_resp(input int k, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack[k] || err[k]) break;
        end
    endtask

    task automatic bus_access(input int k, input logic w, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic [31:0] resp, output int lat);
        @(negedge clk);
        drive_req(k, w, s, a, d);
        wait_resp(k, lat);
        rd   = rdata[k];
        resp = {30'd0, ack[k], err[k]};
        drop_req(k);
        @(negedge clk);
        check_eq($sformatf("dut%0d_pulse_end_%08h", k, a), {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    task automatic write_word(input int k, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input string tag);
        logic [31:0] rd, resp;
        int lat;
        bus_access(k, 1'b1, s, a, d, rd, resp, lat);
        check_eq($sformatf("%s_resp", tag), resp, 32'd2);
        check_eq($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat[k]));
    endtask

    task automatic read_word(input int k, input logic [31:0] a, input logic [31:0] exp,
                             input string tag);
        logic [31:0] rd, resp;
        int lat;
        bus_access(k, 1'b0, 4'h0, a, 32'd0, rd, resp, lat);
        check_eq($sformatf("%s_resp", tag), resp, 32'd2);
        check_eq($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat[k]));
        check_eq($sformatf("%s_data", tag), rd, exp);
    endtask

    task automatic err_access(input int k, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input string tag);
        logic [31:0] rd, resp;
        int lat;
        bus_access(k, w, 4'hF, a, d, rd, resp, lat);
        check_eq($sformatf("%s_resp", tag), resp, 32'd1);
        check_eq($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat[k]));
        check_eq($sformatf("%s_data", tag), rd, 32'd0);
    endtask

    initial begin
        int lat;
        int cnt;
        int nz;
        int ack_cyc [$];
        logic [31:0] ack_dat [$];

        for (int k = 0; k < NDUT; k++) begin
            rst_n[k] = 1'b0;
            drop_req(k);
            wstrb[k] = 4'h0;
            addr[k]  = 32'd0;
            wdata[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("reset_dut%0d_ack_err", k), {30'd0, ack[k], err[k]}, 32'd0);
            check_eq($sformatf("reset_dut%0d_data", k), rdata[k], 32'd0);
        end
        for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
        @(negedge clk);

        // Basic write/read with one wait state
        write_word(1, 32'h10, 32'hDEAD_BEEF, 4'hF, "t1_wr");
        read_word(1, 32'h10, 32'hDEAD_BEEF, "t1_rd");
        read_word(1, 32'h13, 32'hDEAD_BEEF, "t1_rd_low_bits_ignored");

        // Byte lanes: bit n of wstrb covers data[8n+7:8n]
        write_word(1, 32'h20, 32'h1122_3344, 4'hF, "t2_preload");
        write_word(1, 32'h20, 32'hAABB_CCDD, 4'b0101, "t2_wr_0101");
        read_word(1, 32'h20, 32'h11BB_33DD, "t2_rd_0101");
        write_word(1, 32'h20, 32'hFFFF_FFFF, 4'b0000, "t2_wr_nostrb");
        write_word(1, 32'h20, 32'h9900_0000, 4'b1000, "t2_wr_1000");
        read_word(1, 32'h20, 32'h99BB_33DD, "t2_rd_final");

        // Range boundaries
        write_word(1, 32'h0, 32'hC0FF_EE01, 4'hF, "t3_preload0");
        write_word(1, 32'hFFC, 32'h0F0F_0F0F, 4'hF, "t3_wr_last");
        read_word(1, 32'hFFC, 32'h0F0F_0F0F, "t3_rd_last");
        err_access(1, 1'b0, 32'h1000, 32'd0, "t3_rd_oor");
        err_access(1, 1'b1, 32'h1000, 32'h1234_5678, "t3_wr_oor");
        err_access(1, 1'b0, 32'hFFFF_FFFC, 32'd0, "t3_rd_top");
        read_word(1, 32'h0, 32'hC0FF_EE01, "t3_rd_word0_unchanged");
        err_access(2, 1'b0, 32'h0FFC, 32'd0, "t3_rd_below_base");

        // cyc without stb does nothing
        @(negedge clk);
        cyc[1] = 1'b1;
        stb[1] = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) cnt++;
        end
        cyc[1] = 1'b0;
        check_eq("t_cyc_no_stb_resp", 32'(cnt), 32'd0);

        // Abort during wait states
        write_word(2, 32'h1030, 32'h0BAD_F00D, 4'hF, "t4_preload");
        @(negedge clk);
        drive_req(2, 1'b1, 4'hF, 32'h1030, 32'hCAFE_BABE);
        @(posedge clk);
        @(negedge clk);
        drop_req(2);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[2] || err[2]) cnt++;
        end
        check_eq("t4_abort_resp", 32'(cnt), 32'd0);
        read_word(2, 32'h1030, 32'h0BAD_F00D, "t4_rd_old");

        // Request fields are latched at the sample edge
        write_word(2, 32'h1040, 32'h4040_4040, 4'hF, "t4_pre40");
        write_word(2, 32'h1044, 32'h4444_4444, 4'hF, "t4_pre44");
        @(negedge clk);
        drive_req(2, 1'b1, 4'hF, 32'h1040, 32'hABCD_1234);
        @(posedge clk);
        @(negedge clk);
        addr[2]  = 32'h1044;
        wdata[2] = 32'h0;
        wstrb[2] = 4'h0;
        wait_resp(2, lat);
        check_eq("t4_latch_resp", {30'd0, ack[2], err[2]}, 32'd2);
        check_eq("t4_latch_lat", 32'(lat), 32'(exp_lat[2] - 1));
        drop_req(2);
        read_word(2, 32'h1040, 32'hABCD_1234, "t4_rd40");
        read_word(2, 32'h1044, 32'h4444_4444, "t4_rd44");

        // Reset during WAIT of a write
        write_word(2, 32'h1034, 32'h55AA_55AA, 4'hF, "t5_preload34");
        @(negedge clk);
        drive_req(2, 1'b1, 4'hF, 32'h1034, 32'h1212_1212);
        @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        drop_req(2);
        #1;
        check_eq("t5_rst_wait_outs", {ack[2], err[2], 30'd0} | rdata[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        read_word(2, 32'h1034, 32'h55AA_55AA, "t5_rd_after_rst");

        // Reset while ack is high: outputs clear asynchronously, write is dropped
        write_word(2, 32'h1038, 32'h6666_6666, 4'hF, "t5_preload38");
        @(negedge clk);
        drive_req(2, 1'b1, 4'hF, 32'h1038, 32'h7777_7777);
        wait_resp(2, lat);
        check_eq("t5_resp_before_rst", {30'd0, ack[2], err[2]}, 32'd2);
        rst_n[2] = 1'b0;
        drop_req(2);
        #1;
        check_eq("t5_rst_resp_ack", {31'd0, ack[2]}, 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        read_word(2, 32'h1038, 32'h6666_6666, "t5_rd_write_dropped");

        @(negedge clk);
        drive_req(2, 1'b0, 4'h0, 32'h1034, 32'd0);
        wait_resp(2, lat);
        check_eq("t5_rd_data_before_rst", rdata[2], 32'h55AA_55AA);
        rst_n[2] = 1'b0;
        drop_req(2);
        #1;
        check_eq("t5_rst_rd_data", rdata[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;

        // Zero wait states, strobe held: back-to-back reads every second cycle
        write_word(0, 32'h0, 32'hA0A0_A0A0, 4'hF, "t6_pre0");
        write_word(0, 32'h4, 32'hB1B1_B1B1, 4'hF, "t6_pre4");
        write_word(0, 32'h8, 32'hC2C2_C2C2, 4'hF, "t6_pre8");
        @(negedge clk);
        drive_req(0, 1'b0, 4'h0, 32'h0, 32'd0);
        nz  = 0;
        cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (err[0]) cnt++;
            if (ack[0]) begin
                ack_cyc.push_back(c);
                ack_dat.push_back(rdata[0]);
                addr[0] = addr[0] + 32'd4;
                if (ack_cyc.size() == 3) drop_req(0);
            end else if (rdata[0] != 32'd0) begin
                nz++;
            end
        end
        drop_req(0);
        check_eq("t6_ack_count", 32'(ack_cyc.size()), 32'd3);
        check_eq("t6_err_count", 32'(cnt), 32'd0);
        check_eq("t6_data_idle_zero", 32'(nz), 32'd0);
        for (int i = 0; i < ack_cyc.size() && i < 3; i++) begin
            check_eq($sformatf("t6_ack%0d_cycle", i), 32'(ack_cyc[i]), 32'(1 + 2 * i));
        end
        if (ack_dat.size() >= 3) begin
            check_eq("t6_data0", ack_dat[0], 32'hA0A0_A0A0);
            check_eq("t6_data1", ack_dat[1], 32'hB1B1_B1B1);
            check_eq("t6_data2", ack_dat[2], 32'hC2C2_C2C2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
